mux2_rr_arbiter: RTL

- Arbitrates two requesters sharing one 2:1 data mux path: grants, drives the mux select and registers the selected word.
- Round-robin priority between the two requesters.
- Burst-hold limit (MAX_HOLD) preempts a long holder when the other side is waiting.
- Sits between two producer blocks and a single downstream consumer.

---
 rtl/mux2_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-requester arbiter in front of a shared 2:1 data mux.
// Grants are round-robin, and a burst-hold limit (MAX_HOLD) hands the path to
// the other side when it has been waiting too long. The selected word is
// registered on y_o, and y_valid_o marks words captured during a live grant.
//
// Optional build macro MUX2_ARB_FIXED_PRIO_EN: requester 0 wins every idle
// contention and GRANT0 is never preempted. GRANT1 is still preempted by
// req0 at the hold limit.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             sel_o,
  output logic [WIDTH-1:0] y_o,
  output logic             y_valid_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // Count value on which a contended holder is handed over.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             last_q, last_d;     // index of the most recently granted side
  logic [7:0]       cnt_q, cnt_d;       // cycles spent in the current grant
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;

  // Next-state decision: who owns the path after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0_i && !req1_i) begin
          state_d = GRANT0;
        end else if (!req0_i && req1_i) begin
          state_d = GRANT1;
        end else if (req0_i && req1_i) begin
          // last_q==1 means side 1 went last, so side 0 is next.
          state_d = (FIXED_PRIO || last_q) ? GRANT0 : GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (!req0_i) begin
          state_d = req1_i ? GRANT1 : IDLE;
        end else if (req1_i && (cnt_q == HOLD_LAST) && !FIXED_PRIO) begin
          state_d = GRANT1;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        if (!req1_i) begin
          state_d = req0_i ? GRANT0 : IDLE;
        end else if (req0_i && (cnt_q == HOLD_LAST)) begin
          state_d = GRANT0;
        end else begin
          state_d = GRANT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hold counter and last-granted pointer: restart on entry to a grant,
  // saturating count while the same grant is kept.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if ((state_d == GRANT0) && (state_q != GRANT0)) begin
      cnt_d  = 8'd0;
      last_d = 1'b0;
    end else if ((state_d == GRANT1) && (state_q != GRANT1)) begin
      cnt_d  = 8'd0;
      last_d = 1'b1;
    end else if ((state_d == state_q) && (state_q != IDLE)) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : (cnt_q + 8'd1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Data path: capture the granted side's word while it still requests.
  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    if ((state_q == GRANT0) && req0_i) begin
      y_d       = d0_i;
      y_valid_d = 1'b1;
    end else if ((state_q == GRANT1) && req1_i) begin
      y_d       = d1_i;
      y_valid_d = 1'b1;
    end else begin
      y_d       = y_q;
      y_valid_d = 1'b0;
    end
  end

  // State, pointer, counter and output data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  // Grants are direct decodes of the state register, so they are glitch-free
  // and can never both be high.
  assign gnt0_o    = (state_q == GRANT0);
  assign gnt1_o    = (state_q == GRANT1);
  assign sel_o     = (state_q == GRANT1);
  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;

endmodule
